id_ex_stage: RTL

ID/EX pipeline stage of the 5-stage RISC-V core, directly upstream of the ALU. It registers decoded instruction fields and selects forwarded ALU operands (`operand_a`, `operand_b`, `operation`). It also detects load-use hazards, inserts bubbles, and squashes the EX-bound instruction on a taken branch.

---
 rtl/id_ex_stage_if.sv | 96 +++++++++
 rtl/id_ex_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ALU operation encoding shared by decode and the ALU, plus
// the signal bundle between decode, the ID/EX register and the EX/MEM/WB
// forwarding sources.
//   slave  : the ID/EX stage. It takes id_*, the forwarding sources, flush
//            and hold, and drives ex_*, stall_if_id and bubble_count.
//   master : the surrounding pipeline (or a testbench), with the directions
//            reversed.
package id_ex_pkg;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND,
      ALU_PASS_B
   } alu_operation_e;
endpackage

interface id_ex_stage_if
   import id_ex_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
);
   logic           id_valid;
   logic [RW-1:0]  id_rs1_addr;
   logic [RW-1:0]  id_rs2_addr;
   logic [DW-1:0]  id_rs1_data;
   logic [DW-1:0]  id_rs2_data;
   logic [DW-1:0]  id_imm;
   logic [DW-1:0]  id_pc;
   logic [RW-1:0]  id_rd_addr;
   alu_operation_e id_alu_op;
   logic           id_use_pc;
   logic           id_use_imm;
   logic           id_reg_write;
   logic           id_mem_read;
   logic           id_mem_write;
   logic           id_mem_to_reg;

   logic           exmem_reg_write;
   logic [RW-1:0]  exmem_rd_addr;
   logic [DW-1:0]  exmem_result;
   logic           memwb_reg_write;
   logic [RW-1:0]  memwb_rd_addr;
   logic [DW-1:0]  memwb_result;

   logic           flush;
   logic           hold;

   logic           stall_if_id;
   logic           ex_valid;
   logic [DW-1:0]  ex_operand_a;
   logic [DW-1:0]  ex_operand_b;
   alu_operation_e ex_operation;
   logic [DW-1:0]  ex_store_data;
   logic [RW-1:0]  ex_rd_addr;
   logic [DW-1:0]  ex_pc;
   logic [DW-1:0]  ex_imm;
   logic           ex_reg_write;
   logic           ex_mem_read;
   logic           ex_mem_write;
   logic           ex_mem_to_reg;
   logic [31:0]    bubble_count;

   modport slave (
      input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
             id_imm, id_pc, id_rd_addr, id_alu_op, id_use_pc, id_use_imm,
             id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
             exmem_reg_write, exmem_rd_addr, exmem_result,
             memwb_reg_write, memwb_rd_addr, memwb_result,
             flush, hold,
      output stall_if_id, ex_valid, ex_operand_a, ex_operand_b, ex_operation,
             ex_store_data, ex_rd_addr, ex_pc, ex_imm,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
             bubble_count
   );

   modport master (
      output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
             id_imm, id_pc, id_rd_addr, id_alu_op, id_use_pc, id_use_imm,
             id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
             exmem_reg_write, exmem_rd_addr, exmem_result,
             memwb_reg_write, memwb_rd_addr, memwb_result,
             flush, hold,
      input  stall_if_id, ex_valid, ex_operand_a, ex_operand_b, ex_operation,
             ex_store_data, ex_rd_addr, ex_pc, ex_imm,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
             bubble_count
   );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage core.
// It registers the decoded fields, builds the forwarded ALU operands and
// store data, detects load-use hazards, inserts bubbles and squashes the
// instruction entering EX when a branch is taken.
//   clk   : core clock, rising edge
//   reset : asynchronous, active-high
//   bus   : id_ex_stage_if.slave. Inputs are the decode fields, the EX/MEM
//           and MEM/WB forwarding sources, flush and hold. Outputs are the
//           ex_* fields, stall_if_id and bubble_count.
module id_ex_stage
   import id_ex_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          reset,
   id_ex_stage_if.slave  bus
);

   logic           valid_q,      valid_d;
   logic [RW-1:0]  rs1_addr_q,   rs1_addr_d;
   logic [RW-1:0]  rs2_addr_q,   rs2_addr_d;
   logic [DW-1:0]  rs1_data_q,   rs1_data_d;
   logic [DW-1:0]  rs2_data_q,   rs2_data_d;
   logic [DW-1:0]  imm_q,        imm_d;
   logic [DW-1:0]  pc_q,         pc_d;
   logic [RW-1:0]  rd_addr_q,    rd_addr_d;
   alu_operation_e op_q,         op_d;
   logic           use_pc_q,     use_pc_d;
   logic           use_imm_q,    use_imm_d;
   logic           reg_write_q,  reg_write_d;
   logic           mem_read_q,   mem_read_d;
   logic           mem_write_q,  mem_write_d;
   logic           mem_to_reg_q, mem_to_reg_d;
   logic [31:0]    bubble_count_q, bubble_count_d;

   logic           load_use;
   logic [DW-1:0]  fwd_rs1;
   logic [DW-1:0]  fwd_rs2;

   // A load in EX whose rd matches either id source address. Matching is
   // purely on address: rs2 counts even when decode will use the immediate.
   always_comb begin
      load_use = valid_q & mem_read_q & bus.id_valid & (rd_addr_q != '0) &
                 ((rd_addr_q == bus.id_rs1_addr) | (rd_addr_q == bus.id_rs2_addr));
   end

   // A taken branch squashes the dependent instruction anyway, so the
   // load-use stall is not needed in that case.
   assign bus.stall_if_id = (load_use & ~bus.flush) | bus.hold;

   always_comb begin
      valid_d        = valid_q;
      rs1_addr_d     = rs1_addr_q;
      rs2_addr_d     = rs2_addr_q;
      rs1_data_d     = rs1_data_q;
      rs2_data_d     = rs2_data_q;
      imm_d          = imm_q;
      pc_d           = pc_q;
      rd_addr_d      = rd_addr_q;
      op_d           = op_q;
      use_pc_d       = use_pc_q;
      use_imm_d      = use_imm_q;
      reg_write_d    = reg_write_q;
      mem_read_d     = mem_read_q;
      mem_write_d    = mem_write_q;
      mem_to_reg_d   = mem_to_reg_q;
      bubble_count_d = bubble_count_q;

      if (bus.hold) begin
         // everything, including the bubble counter, stays put
      end else if (bus.flush || load_use) begin
         // bubble: data fields are left as they were, they are don't-care
         valid_d        = 1'b0;
         reg_write_d    = 1'b0;
         mem_read_d     = 1'b0;
         mem_write_d    = 1'b0;
         mem_to_reg_d   = 1'b0;
         op_d           = ALU_ADD;
         bubble_count_d = bubble_count_q + 32'd1;
      end else begin
         valid_d      = bus.id_valid;
         rs1_addr_d   = bus.id_rs1_addr;
         rs2_addr_d   = bus.id_rs2_addr;
         rs1_data_d   = bus.id_rs1_data;
         rs2_data_d   = bus.id_rs2_data;
         imm_d        = bus.id_imm;
         pc_d         = bus.id_pc;
         rd_addr_d    = bus.id_rd_addr;
         op_d         = bus.id_alu_op;
         use_pc_d     = bus.id_use_pc;
         use_imm_d    = bus.id_use_imm;
         reg_write_d  = bus.id_reg_write;
         mem_read_d   = bus.id_mem_read;
         mem_write_d  = bus.id_mem_write;
         mem_to_reg_d = bus.id_mem_to_reg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q        <= 1'b0;
         rs1_addr_q     <= '0;
         rs2_addr_q     <= '0;
         rs1_data_q     <= '0;
         rs2_data_q     <= '0;
         imm_q          <= '0;
         pc_q           <= '0;
         rd_addr_q      <= '0;
         op_q           <= ALU_ADD;
         use_pc_q       <= 1'b0;
         use_imm_q      <= 1'b0;
         reg_write_q    <= 1'b0;
         mem_read_q     <= 1'b0;
         mem_write_q    <= 1'b0;
         mem_to_reg_q   <= 1'b0;
         bubble_count_q <= '0;
      end else begin
         valid_q        <= valid_d;
         rs1_addr_q     <= rs1_addr_d;
         rs2_addr_q     <= rs2_addr_d;
         rs1_data_q     <= rs1_data_d;
         rs2_data_q     <= rs2_data_d;
         imm_q          <= imm_d;
         pc_q           <= pc_d;
         rd_addr_q      <= rd_addr_d;
         op_q           <= op_d;
         use_pc_q       <= use_pc_d;
         use_imm_q      <= use_imm_d;
         reg_write_q    <= reg_write_d;
         mem_read_q     <= mem_read_d;
         mem_write_q    <= mem_write_d;
         mem_to_reg_q   <= mem_to_reg_d;
         bubble_count_q <= bubble_count_d;
      end
   end

   // EX/MEM is the younger producer, so it wins over MEM/WB. x0 is never
   // forwarded, so it always reads as the register-file value.
   always_comb begin
      fwd_rs1 = rs1_data_q;
      if (bus.exmem_reg_write && (bus.exmem_rd_addr != '0) &&
          (bus.exmem_rd_addr == rs1_addr_q)) begin
         fwd_rs1 = bus.exmem_result;
      end else if (bus.memwb_reg_write && (bus.memwb_rd_addr != '0) &&
                   (bus.memwb_rd_addr == rs1_addr_q)) begin
         fwd_rs1 = bus.memwb_result;
      end
   end

   always_comb begin
      fwd_rs2 = rs2_data_q;
      if (bus.exmem_reg_write && (bus.exmem_rd_addr != '0) &&
          (bus.exmem_rd_addr == rs2_addr_q)) begin
         fwd_rs2 = bus.exmem_result;
      end else if (bus.memwb_reg_write && (bus.memwb_rd_addr != '0) &&
                   (bus.memwb_rd_addr == rs2_addr_q)) begin
         fwd_rs2 = bus.memwb_result;
      end
   end

   assign bus.ex_operand_a  = use_pc_q  ? pc_q  : fwd_rs1;
   assign bus.ex_operand_b  = use_imm_q ? imm_q : fwd_rs2;
   assign bus.ex_store_data = fwd_rs2;

   assign bus.ex_valid      = valid_q;
   assign bus.ex_operation  = op_q;
   assign bus.ex_rd_addr    = rd_addr_q;
   assign bus.ex_pc         = pc_q;
   assign bus.ex_imm        = imm_q;
   assign bus.ex_reg_write  = valid_q & reg_write_q;
   assign bus.ex_mem_read   = valid_q & mem_read_q;
   assign bus.ex_mem_write  = valid_q & mem_write_q;
   assign bus.ex_mem_to_reg = valid_q & mem_to_reg_q;
   assign bus.bubble_count  = bubble_count_q;

endmodule
